// File: rtl/rib_wb_bridge.sv
// Multi-port RIB to classic Wishbone master bridge: arbitrates N requesters onto one bus,
// handles wait states, bus errors and an optional stb timeout, and stalls the core via hold_o.
module rib_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int N_PORTS        = 2,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_PORTS-1:0]              req_i,
    input  logic [N_PORTS-1:0]              we_i,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   wdata_i,
    input  logic [N_PORTS*DATA_WIDTH/8-1:0] sel_i,
    output logic [N_PORTS*DATA_WIDTH-1:0]   rdata_o,
    output logic [N_PORTS-1:0]              done_o,
    output logic [N_PORTS-1:0]              err_o,
    output logic                            hold_o,
    output logic                            wb_cyc_o,
    output logic                            wb_stb_o,
    output logic                            wb_we_o,
    output logic [ADDR_WIDTH-1:0]           wb_addr_o,
    output logic [DATA_WIDTH-1:0]           wb_data_o,
    output logic [DATA_WIDTH/8-1:0]         wb_sel_o,
    input  logic [DATA_WIDTH-1:0]           wb_data_i,
    input  logic                            wb_ack_i,
    input  logic                            wb_err_i
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int GNT_WIDTH = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUS  = 1'b1;

    logic                  state_reg;
    logic                  cyc_reg;
    logic                  we_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [SEL_WIDTH-1:0]  sel_reg;
    logic [GNT_WIDTH-1:0]  gnt_reg;
    logic [GNT_WIDTH-1:0]  last_grant_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;

    logic [ADDR_WIDTH-1:0] port_addr  [N_PORTS];
    logic [DATA_WIDTH-1:0] port_wdata [N_PORTS];
    logic [SEL_WIDTH-1:0]  port_sel   [N_PORTS];
    logic [DATA_WIDTH-1:0] rdata_reg  [N_PORTS];

    logic                  gnt_valid;
    logic [GNT_WIDTH-1:0]  gnt_idx;
    logic                  bus_active;
    logic                  timeout_hit;
    logic                  finish;
    logic                  finish_err;
    logic                  rd_load;
    logic [DATA_WIDTH-1:0] rdata_next;

    // Arbiter: scan all ports starting from the lowest index, or from last_grant+1 in round-robin mode.
    always_comb begin
        int                   cand;
        logic [GNT_WIDTH-1:0] cand_idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = (ARB_MODE == 1) ? int'(last_grant_reg) + 1 + i : i;
            if (cand >= N_PORTS) begin
                cand = cand - N_PORTS;
            end
            cand_idx = GNT_WIDTH'(cand);
            if (!gnt_valid && req_i[cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // Slave responses only count once stb is actually on the bus; err outranks ack, both outrank timeout.
    assign bus_active  = (state_reg == ST_BUS) && cyc_reg;
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_reg == CNT_WIDTH'(TIMEOUT_CYCLES));
    assign finish      = bus_active && (wb_err_i || wb_ack_i || timeout_hit);
    assign finish_err  = bus_active && (wb_err_i || (!wb_ack_i && timeout_hit));
    assign rd_load     = bus_active && !we_reg && !wb_err_i && (wb_ack_i || timeout_hit);
    assign rdata_next  = wb_ack_i ? wb_data_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cyc_reg        <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            sel_reg        <= '0;
            gnt_reg        <= '0;
            last_grant_reg <= GNT_WIDTH'(N_PORTS - 1);
            cnt_reg        <= '0;
        end else if (state_reg == ST_IDLE) begin
            if (gnt_valid) begin
                state_reg      <= ST_BUS;
                gnt_reg        <= gnt_idx;
                last_grant_reg <= gnt_idx;
                we_reg         <= we_i[gnt_idx];
                addr_reg       <= port_addr[gnt_idx];
                wdata_reg      <= port_wdata[gnt_idx];
                sel_reg        <= port_sel[gnt_idx];
                cnt_reg        <= '0;
            end
        end else begin
            if (cnt_reg != '1) begin
                cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            end
            // The first BUS cycle only launches cyc/stb from the latched request.
            if (!cyc_reg) begin
                cyc_reg <= 1'b1;
            end else if (finish) begin
                state_reg <= ST_IDLE;
                cyc_reg   <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
            logic done_reg;
            logic err_reg;

            assign port_addr[gi]  = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign port_wdata[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign port_sel[gi]   = sel_i[gi*SEL_WIDTH +: SEL_WIDTH];
            assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_reg[gi];
            assign done_o[gi] = done_reg;
            assign err_o[gi]  = err_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    done_reg      <= 1'b0;
                    err_reg       <= 1'b0;
                    rdata_reg[gi] <= '0;
                end else begin
                    done_reg <= finish && (gnt_reg == GNT_WIDTH'(gi));
                    err_reg  <= finish_err && (gnt_reg == GNT_WIDTH'(gi));
                    if (rd_load && (gnt_reg == GNT_WIDTH'(gi))) begin
                        rdata_reg[gi] <= rdata_next;
                    end
                end
            end
        end
    endgenerate

    assign hold_o    = |(req_i & ~done_o);
    assign wb_cyc_o  = cyc_reg;
    assign wb_stb_o  = cyc_reg;
    assign wb_we_o   = we_reg;
    assign wb_addr_o = addr_reg;
    assign wb_data_o = wdata_reg;
    assign wb_sel_o  = sel_reg;

endmodule

// File: tb/tb_rib_wb_bridge.sv
// Bench for rib_wb_bridge: a fixed-priority instance with an 8-cycle timeout and a round-robin
// instance without timeout, each behind a small behavioural Wishbone slave.
module tb_rib_wb_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req, we_v;
    logic [63:0] addr_v, wdata_v;
    logic [7:0]  sel_v;

    logic [63:0] a_rdata, b_rdata;
    logic [1:0]  a_done, a_err, b_done, b_err;
    logic        a_hold, a_cyc, a_stb, a_we, b_hold, b_cyc, b_stb, b_we;
    logic [31:0] a_addr, a_wdat, a_rdin, b_addr, b_wdat, b_rdin;
    logic [3:0]  a_sel, b_sel;
    logic        a_ack, a_errin, b_ack, b_errin;

    rib_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .N_PORTS(2), .ARB_MODE(0), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we_v), .addr_i(addr_v), .wdata_i(wdata_v),
        .sel_i(sel_v), .rdata_o(a_rdata), .done_o(a_done), .err_o(a_err), .hold_o(a_hold),
        .wb_cyc_o(a_cyc), .wb_stb_o(a_stb), .wb_we_o(a_we), .wb_addr_o(a_addr), .wb_data_o(a_wdat),
        .wb_sel_o(a_sel), .wb_data_i(a_rdin), .wb_ack_i(a_ack), .wb_err_i(a_errin));

    rib_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .N_PORTS(2), .ARB_MODE(1), .TIMEOUT_CYCLES(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we_v), .addr_i(addr_v), .wdata_i(wdata_v),
        .sel_i(sel_v), .rdata_o(b_rdata), .done_o(b_done), .err_o(b_err), .hold_o(b_hold),
        .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_we_o(b_we), .wb_addr_o(b_addr), .wb_data_o(b_wdat),
        .wb_sel_o(b_sel), .wb_data_i(b_rdin), .wb_ack_i(b_ack), .wb_err_i(b_errin));

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic [31:0] ref_rdata [2];
    int          s_wait = 0;
    int          s_mode = 0;   // 0 ack, 1 err, 2 ack+err together, 3 never respond
    logic        b_noack = 1'b0;

    // Slave for the fixed-priority instance: memory with programmable wait states and response kind.
    initial begin
        int wcnt;
        wcnt = 0; a_ack = 1'b0; a_errin = 1'b0; a_rdin = '0;
        forever begin
            @(negedge clk);
            if (a_cyc && a_stb) begin
                if (wcnt == s_wait && s_mode != 3) begin
                    a_ack   = (s_mode != 1);
                    a_errin = (s_mode != 0);
                    a_rdin  = (s_mode == 0) ? mem[a_addr[5:2]] : $urandom;
                    if (s_mode == 0 && a_we) begin
                        for (int b = 0; b < 4; b++)
                            if (a_sel[b]) mem[a_addr[5:2]][b*8 +: 8] = a_wdat[b*8 +: 8];
                    end
                end else begin
                    a_ack = 1'b0; a_errin = 1'b0; a_rdin = $urandom;
                end
                wcnt++;
            end else begin
                wcnt = 0; a_ack = 1'b0; a_errin = 1'b0;
            end
        end
    end

    // Slave for the round-robin instance: zero-wait ack unless b_noack stalls it.
    initial begin
        b_ack = 1'b0; b_errin = 1'b0; b_rdin = '0;
        forever begin
            @(negedge clk);
            b_ack  = b_cyc && b_stb && !b_noack;
            b_rdin = $urandom;
        end
    end

    task automatic do_txn(input int p, input logic w, input logic [31:0] ad, input logic [31:0] wd,
                          input logic [3:0] sl, output int lat, output int stbs, output logic e,
                          output logic stable, output logic hold_ok, output logic again);
        logic [68:0] snap;
        @(negedge clk);
        req = '0; req[p] = 1'b1; we_v[p] = w;
        addr_v[p*32 +: 32] = ad; wdata_v[p*32 +: 32] = wd; sel_v[p*4 +: 4] = sl;
        lat = 0; stbs = 0; e = 1'b0; stable = 1'b1; hold_ok = 1'b1; snap = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (a_done[p]) begin
                lat = n; e = a_err[p];
                if (a_hold) hold_ok = 1'b0;
                break;
            end
            if (!a_hold) hold_ok = 1'b0;
            if (a_stb) begin
                stbs++;
                if (stbs == 1) snap = {a_we, a_sel, a_addr, a_wdat};
                else if (snap != {a_we, a_sel, a_addr, a_wdat}) stable = 1'b0;
            end
        end
        @(negedge clk); req = '0;
        @(posedge clk); #1; again = a_done[p];
        $display("txn port=%0d we=%0b addr=%h wdata=%h lat=%0d stb=%0d err=%0b rdata=%h",
                 p, w, ad, wd, lat, stbs, e, a_rdata[p*32 +: 32]);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 2'b01;
        repeat (2) @(posedge clk); #1;
        vectors++; if ({a_cyc, a_stb, a_we} !== 3'b000) begin miscompares++; $display("FAIL reset_ctrl: got %b expected 000", {a_cyc, a_stb, a_we}); end
        vectors++; if ({a_addr, a_wdat, a_sel} !== 68'h0) begin miscompares++; $display("FAIL reset_bus: got %h expected 0", {a_addr, a_wdat, a_sel}); end
        vectors++; if ({a_done, a_err} !== 4'h0) begin miscompares++; $display("FAIL reset_done_err: got %b expected 0000", {a_done, a_err}); end
        vectors++; if (a_rdata !== 64'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0", a_rdata); end
        vectors++; if (a_hold !== 1'b1) begin miscompares++; $display("FAIL reset_hold_req: got %b expected 1", a_hold); end
        req = 2'b00; #1;
        vectors++; if (a_hold !== 1'b0) begin miscompares++; $display("FAIL reset_hold_idle: got %b expected 0", a_hold); end
        @(negedge clk); rst_n = 1'b1;
        ref_rdata[0] = '0; ref_rdata[1] = '0;
    endtask

    task automatic test_zero_wait_read;
        int lat, stbs; logic e, st, hk, ag;
        mem[0] = 32'hCAFEBABE; ref_mem[0] = 32'hCAFEBABE;
        s_wait = 0; s_mode = 0;
        do_txn(0, 1'b0, 32'h100, 32'h0, 4'hF, lat, stbs, e, st, hk, ag);
        ref_rdata[0] = ref_mem[0];
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL zw_latency: got %0d expected 3", lat); end
        vectors++; if (stbs !== 1) begin miscompares++; $display("FAIL zw_cyc_cycles: got %0d expected 1", stbs); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL zw_err: got %b expected 0", e); end
        vectors++; if (a_rdata[31:0] !== 32'hCAFEBABE) begin miscompares++; $display("FAIL zw_rdata: got %h expected cafebabe", a_rdata[31:0]); end
        vectors++; if (hk !== 1'b1) begin miscompares++; $display("FAIL zw_hold: got %b expected 1", hk); end
        vectors++; if (ag !== 1'b0) begin miscompares++; $display("FAIL zw_done_once: got %b expected 0", ag); end
    endtask

    task automatic test_wait_write;
        int lat, stbs; logic e, st, hk, ag;
        s_wait = 4; s_mode = 0;
        do_txn(1, 1'b1, 32'h200, 32'h12345678, 4'hF, lat, stbs, e, st, hk, ag);
        ref_mem[0] = 32'h12345678;
        vectors++; if (stbs !== 5) begin miscompares++; $display("FAIL ws_stb_cycles: got %0d expected 5", stbs); end
        vectors++; if (lat !== 7) begin miscompares++; $display("FAIL ws_latency: got %0d expected 7", lat); end
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL ws_bus_stable: got %b expected 1", st); end
        vectors++; if (a_rdata[63:32] !== ref_rdata[1]) begin miscompares++; $display("FAIL ws_rdata_kept: got %h expected %h", a_rdata[63:32], ref_rdata[1]); end
        vectors++; if (ag !== 1'b0) begin miscompares++; $display("FAIL ws_done_once: got %b expected 0", ag); end
        vectors++; if (mem[0] !== 32'h12345678) begin miscompares++; $display("FAIL ws_slave_written: got %h expected 12345678", mem[0]); end
        s_wait = 0;
    endtask

    task automatic test_arbitration;
        int a0, a1; int bq[$];
        a0 = 0; a1 = 0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        ref_rdata[0] = '0; ref_rdata[1] = '0;
        s_wait = 0; s_mode = 0;
        req = 2'b11; we_v = 2'b00; addr_v = {32'h1014, 32'h1008}; sel_v = 8'hFF;
        for (int n = 0; n < 13; n++) begin
            @(posedge clk); #1;
            if (a_done[0]) a0++;
            if (a_done[1]) a1++;
            if (b_done[0]) bq.push_back(0);
            if (b_done[1]) bq.push_back(1);
        end
        @(negedge clk); req = 2'b00;
        repeat (6) @(posedge clk);
        ref_rdata[0] = ref_mem[2];
        $display("arb fixed: port0=%0d port1=%0d  rr grants=%0d", a0, a1, bq.size());
        vectors++; if (a0 !== 4) begin miscompares++; $display("FAIL arb_fixed_p0: got %0d expected 4", a0); end
        vectors++; if (a1 !== 0) begin miscompares++; $display("FAIL arb_fixed_p1_starved: got %0d expected 0", a1); end
        vectors++; if (bq.size() !== 4) begin miscompares++; $display("FAIL arb_rr_count: got %0d expected 4", bq.size()); end
        for (int i = 0; i < 4 && i < bq.size(); i++) begin
            vectors++; if (bq[i] !== i % 2) begin miscompares++; $display("FAIL arb_rr_order[%0d]: got %0d expected %0d", i, bq[i], i % 2); end
        end
        vectors++; if (a_rdata[31:0] !== ref_rdata[0]) begin miscompares++; $display("FAIL arb_rdata: got %h expected %h", a_rdata[31:0], ref_rdata[0]); end
    endtask

    task automatic test_random;
        for (int t = 0; t < 30; t++) begin
            int p, idx, wt, md, lat, stbs, exp_lat, exp_stb;
            logic w, e, st, hk, ag, exp_err;
            logic [31:0] wd;
            logic [3:0] sl;
            p = $urandom_range(0, 1); idx = $urandom_range(0, 15); w = 1'($urandom_range(0, 1));
            wd = $urandom; sl = 4'($urandom_range(1, 15)); wt = $urandom_range(0, 3);
            md = $urandom_range(0, 9);
            md = (md < 7) ? 0 : ((md < 9 || w) ? 1 : 3);
            s_wait = wt; s_mode = md;
            if (md == 3) begin
                exp_lat = 10; exp_stb = 8; exp_err = 1'b1; ref_rdata[p] = '0;
            end else begin
                exp_lat = wt + 3; exp_stb = wt + 1; exp_err = (md != 0);
                if (md == 0 && w) begin
                    for (int b = 0; b < 4; b++) if (sl[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
                end else if (md == 0) begin
                    ref_rdata[p] = ref_mem[idx];
                end
            end
            do_txn(p, w, 32'h1000 + 32'(idx * 4), wd, sl, lat, stbs, e, st, hk, ag);
            vectors++; if (lat !== exp_lat) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d expected %0d", t, lat, exp_lat); end
            vectors++; if (stbs !== exp_stb) begin miscompares++; $display("FAIL rnd%0d_stb: got %0d expected %0d", t, stbs, exp_stb); end
            vectors++; if (e !== exp_err) begin miscompares++; $display("FAIL rnd%0d_err: got %b expected %b", t, e, exp_err); end
            vectors++; if (a_rdata[p*32 +: 32] !== ref_rdata[p]) begin miscompares++; $display("FAIL rnd%0d_rdata: got %h expected %h", t, a_rdata[p*32 +: 32], ref_rdata[p]); end
            vectors++; if (ag !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_done_once: got %b expected 0", t, ag); end
        end
        s_wait = 0; s_mode = 0;
    endtask

    task automatic test_ack_err;
        int lat, stbs; logic e, st, hk, ag;
        s_wait = 0; s_mode = 0;
        do_txn(1, 1'b0, 32'h1028, 32'h0, 4'hF, lat, stbs, e, st, hk, ag);
        ref_rdata[1] = ref_mem[10];
        vectors++; if (a_rdata[63:32] !== ref_rdata[1]) begin miscompares++; $display("FAIL ae_preload: got %h expected %h", a_rdata[63:32], ref_rdata[1]); end
        s_mode = 2;
        do_txn(1, 1'b0, 32'h1030, 32'h0, 4'hF, lat, stbs, e, st, hk, ag);
        vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL ae_err_wins: got %b expected 1", e); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL ae_latency: got %0d expected 3", lat); end
        vectors++; if (a_rdata[63:32] !== ref_rdata[1]) begin miscompares++; $display("FAIL ae_rdata_kept: got %h expected %h", a_rdata[63:32], ref_rdata[1]); end
        s_mode = 0;
    endtask

    task automatic test_timeout;
        int lat, stbs; logic e, st, hk, ag;
        s_wait = 0; s_mode = 0;
        do_txn(0, 1'b0, 32'h1004, 32'h0, 4'hF, lat, stbs, e, st, hk, ag);
        ref_rdata[0] = ref_mem[1];
        vectors++; if (a_rdata[31:0] !== ref_rdata[0]) begin miscompares++; $display("FAIL to_preload: got %h expected %h", a_rdata[31:0], ref_rdata[0]); end
        s_mode = 3;
        do_txn(0, 1'b0, 32'h1004, 32'h0, 4'hF, lat, stbs, e, st, hk, ag);
        ref_rdata[0] = '0;
        vectors++; if (stbs !== 8) begin miscompares++; $display("FAIL to_stb_cycles: got %0d expected 8", stbs); end
        vectors++; if (lat !== 10) begin miscompares++; $display("FAIL to_latency: got %0d expected 10", lat); end
        vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL to_err: got %b expected 1", e); end
        vectors++; if (a_rdata[31:0] !== 32'h0) begin miscompares++; $display("FAIL to_rdata_zero: got %h expected 0", a_rdata[31:0]); end
        s_mode = 0;
    endtask

    task automatic test_no_timeout;
        int bdone; logic got;
        bdone = 0; got = 1'b0;
        s_wait = 0; s_mode = 0; b_noack = 1'b1;
        @(negedge clk);
        req = 2'b01; we_v = 2'b00; addr_v[31:0] = 32'h100C;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (b_done[0]) bdone++;
        end
        vectors++; if (bdone !== 0) begin miscompares++; $display("FAIL nt_no_done: got %0d expected 0", bdone); end
        vectors++; if (b_stb !== 1'b1) begin miscompares++; $display("FAIL nt_stb_held: got %b expected 1", b_stb); end
        b_noack = 1'b0;
        for (int n = 0; n < 5 && !got; n++) begin
            @(posedge clk); #1;
            if (b_done[0]) got = 1'b1;
        end
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL nt_completes: got %b expected 1", got); end
        $display("txn rr port=0 stalled 40 cycles, released done=%0b", got);
        @(negedge clk); req = 2'b00;
        repeat (6) @(posedge clk);
        ref_rdata[0] = ref_mem[3];
    endtask

    task automatic test_reset_mid_bus;
        int lat;
        lat = 0; s_wait = 10; s_mode = 0;
        @(negedge clk);
        req = 2'b01; we_v = 2'b00; addr_v[31:0] = 32'h1018;
        repeat (3) @(posedge clk); #1;
        vectors++; if (a_cyc !== 1'b1) begin miscompares++; $display("FAIL rm_in_bus: got %b expected 1", a_cyc); end
        rst_n = 1'b0; #1;
        ref_rdata[0] = '0; ref_rdata[1] = '0;
        vectors++; if ({a_cyc, a_stb} !== 2'b00) begin miscompares++; $display("FAIL rm_cyc_async: got %b expected 00", {a_cyc, a_stb}); end
        vectors++; if (a_rdata !== 64'h0) begin miscompares++; $display("FAIL rm_rdata_cleared: got %h expected 0", a_rdata); end
        s_wait = 0;
        @(negedge clk); rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (a_done[0]) begin lat = n; break; end
        end
        ref_rdata[0] = ref_mem[6];
        $display("txn port=0 regrant after reset lat=%0d rdata=%h", lat, a_rdata[31:0]);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rm_regrant_latency: got %0d expected 3", lat); end
        vectors++; if (a_rdata[31:0] !== ref_rdata[0]) begin miscompares++; $display("FAIL rm_rdata: got %h expected %h", a_rdata[31:0], ref_rdata[0]); end
        @(negedge clk); req = 2'b00;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0; we_v = '0; addr_v = '0; wdata_v = '0; sel_v = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom | 32'h1;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_arbitration();
        test_random();
        test_ack_err();
        test_timeout();
        test_no_timeout();
        test_reset_mid_bus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rib_wb_bridge.md
# rib_wb_bridge

- Multi-port bridge that turns tinyriscv-style RIB requests (req/we/addr/data) into classic Wishbone transactions on a single shared master bus.
- Supports real wait states, bus errors and timeouts; stalls requesting ports through `hold_o` until their transaction completes.
- Sits between the core and the Controller memory port in `processorci_top`, replacing the tie-off glue (constant ack, `cyc = stb`).
- Lets fetch and data share one memory with N_PORTS generalised arbitration.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width, multiple of 8.
- `N_PORTS`, default 2: number of RIB requesters; port 0 = data, port 1 = fetch in the top.
- `ARB_MODE`, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- `TIMEOUT_CYCLES`, default 255: cycles of `stb` without `ack`/`err` before abort; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_i`  in  N_PORTS  per-port request; held stable until that port's `done_o`.
- `we_i`  in  N_PORTS  per-port write enable.
- `addr_i`  in  N_PORTS*ADDR_WIDTH  packed addresses; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- `wdata_i`  in  N_PORTS*DATA_WIDTH  packed write data.
- `sel_i`  in  N_PORTS*DATA_WIDTH/8  packed byte selects.
- `rdata_o`  out  N_PORTS*DATA_WIDTH  per-port registered read data.
- `done_o`  out  N_PORTS  one-cycle completion pulse.
- `err_o`  out  N_PORTS  one-cycle error pulse, coincident with `done_o`.
- `hold_o`  out  1  stall to core = |(req_i & ~done_o), combinational.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone controls.
- `wb_addr_o`  out  ADDR_WIDTH  Wishbone address.
- `wb_data_o`  out  DATA_WIDTH  Wishbone write data.
- `wb_sel_o`  out  DATA_WIDTH/8  Wishbone byte selects.
- `wb_data_i`  in  DATA_WIDTH  Wishbone read data.
- `wb_ack_i`, `wb_err_i`  in  1 each  Wishbone ack / error.

## Operation
- FSM states:
  - IDLE: if |req_i, select a grant and latch that port's we/addr/wdata/sel and index. Go to BUS.
  - BUS: `wb_cyc_o` = `wb_stb_o` = 1, driven from the latched registers. Timeout counter increments each cycle.
    - On `wb_err_i`: `err_o[g]` and `done_o[g]` pulse; `rdata_o[g]` is unchanged; go to IDLE.
    - On `wb_ack_i`: `done_o[g]` pulses; if the transaction is a read, `rdata_o[g]` ← `wb_data_i`; go to IDLE.
    - On counter == TIMEOUT_CYCLES (when TIMEOUT_CYCLES > 0): `err_o[g]` and `done_o[g]` pulse, `rdata_o[g]` ← 0, go to IDLE.
- Precedence: if `wb_err_i` and `wb_ack_i` arrive together, err wins; timeout only fires when neither is asserted.
- Arbitration:
  - ARB_MODE 0: lowest set index wins.
  - ARB_MODE 1: search starts at last_grant+1 modulo N_PORTS. last_grant resets to N_PORTS-1, so port 0 goes first.
- Writes never modify `rdata_o`. `rdata_o[p]` holds its value until the next read completion on port p.
- A port deasserting `req_i` mid-transaction does not abort it; the transaction completes and `done_o` still pulses.
- The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide, cleared on entry to BUS, and saturates.

## Timing
- Reset (async assert): state IDLE. All outputs 0: `wb_*_o`, `done_o`, `err_o`, `rdata_o`. `hold_o` follows `req_i` combinationally. A transaction in flight is dropped immediately.
- Latency: `req_i` sampled at edge 0 → `wb_cyc_o`/`wb_stb_o` high after edge 1 → ack sampled at edge k → `done_o` high during the cycle after edge k, and `cyc`/`stb` low in that same cycle.
- Zero-wait slave (ack in the first stb cycle): 3 cycles per transaction. Each slave wait state adds 1 cycle.
- In the done cycle the FSM is in IDLE and may grant again. `cyc` therefore drops for at least one cycle between transactions.
- `wb_*_o` are registered and stable for the whole BUS state.

## Test plan
- Zero-wait slave, port 0 read of 0x100 returning 0xCAFEBABE → `cyc` high exactly 1 cycle, `done_o[0]` pulses on cycle 3, `rdata_o[0]` = 0xCAFEBABE, `hold_o` low from the done cycle.
- Slave inserting 4 wait states, port 1 write of 0x12345678 with sel 0xF → `cyc`/`stb` high 5 cycles, `wb_data_o` stable, `rdata_o[1]` unchanged, `done_o[1]` pulses once.
- `req_i` = 2'b11 held continuously, ARB_MODE 0 → port 0 is served repeatedly and port 1 starves. With ARB_MODE 1 → grants alternate 0,1,0,1.
- Slave never acks, TIMEOUT_CYCLES = 8 → `stb` high 8 cycles, then `done_o`/`err_o` pulse together and `rdata_o` = 0. With TIMEOUT_CYCLES = 0 → bus waits indefinitely.
- `wb_ack_i` and `wb_err_i` asserted in the same cycle on a read → `err_o` pulses and `rdata_o` keeps its previous value.
- `rst_n` asserted mid-BUS → `wb_cyc_o` low within the same cycle (async). After release, a pending `req_i` is re-granted from IDLE with the normal 3-cycle latency.
